// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// Module  : branch_resolve_unit_if
// Brief   : Prediction / execute / redirect / training bundle for the branch
//           resolve unit. Perf counters present only with BRU_PERF_CNT_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              pred_valid_1;
   logic [ADDR_W-1:0] pred_pc_1;
   logic              pred_is_branch_1;
   logic              pred_taken_1;
   logic [ADDR_W-1:0] pred_target_1;
   logic              pred_valid_2;
   logic [ADDR_W-1:0] pred_pc_2;
   logic              pred_is_branch_2;
   logic              pred_taken_2;
   logic [ADDR_W-1:0] pred_target_2;
   logic              pred_ready;

   logic              ex_valid;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_is_branch;
   logic              ex_taken;
   logic [ADDR_W-1:0] ex_target;

   logic              flush_o;
   logic [ADDR_W-1:0] redirect_pc_o;
   logic              upd_valid_o;
   logic [ADDR_W-1:0] upd_pc_o;
   logic              upd_is_branch_o;
   logic              upd_taken_o;
   logic [ADDR_W-1:0] upd_target_o;
   logic [CNT_W-1:0]  count_o;
`ifdef BRU_PERF_CNT_EN
   logic [31:0]       perf_resolved_o;
   logic [31:0]       perf_mispred_o;
`endif

   modport master (
      output pred_valid_1, pred_pc_1, pred_is_branch_1, pred_taken_1, pred_target_1,
      output pred_valid_2, pred_pc_2, pred_is_branch_2, pred_taken_2, pred_target_2,
      input  pred_ready,
      output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
      input  flush_o, redirect_pc_o,
      input  upd_valid_o, upd_pc_o, upd_is_branch_o, upd_taken_o, upd_target_o,
`ifdef BRU_PERF_CNT_EN
      input  perf_resolved_o, perf_mispred_o,
`endif
      input  count_o
   );

   modport slave (
      input  pred_valid_1, pred_pc_1, pred_is_branch_1, pred_taken_1, pred_target_1,
      input  pred_valid_2, pred_pc_2, pred_is_branch_2, pred_taken_2, pred_target_2,
      output pred_ready,
      input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
      output flush_o, redirect_pc_o,
      output upd_valid_o, upd_pc_o, upd_is_branch_o, upd_taken_o, upd_target_o,
`ifdef BRU_PERF_CNT_EN
      output perf_resolved_o, perf_mispred_o,
`endif
      output count_o
   );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : In-order prediction queue checked against execute outcomes; issues
//           registered flush/redirect and predictor training writes.
//           Optional macro BRU_PERF_CNT_EN adds resolved/mispredict counters.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  wire logic clk,
   input  wire logic rst,
   branch_resolve_unit_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail2;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
   logic [ADDR_W-1:0] tgt_mem_q [DEPTH];
   logic              br_mem_q  [DEPTH];
   logic              tk_mem_q  [DEPTH];

   logic              flush_q, flush_d;
   logic [ADDR_W-1:0] redirect_q, redirect_d;
   logic              upd_valid_q, upd_valid_d;
   logic [ADDR_W-1:0] upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
   logic              upd_br_q, upd_br_d, upd_tk_q, upd_tk_d;

   logic              ready, enq1, enq2, wr1, wr2, do_res, mispred;
   logic [CNT_W-1:0]  n_enq;
   logic [ADDR_W-1:0] next_pc;

   always_comb begin
      ready   = (state_q == ST_RUN) && (count_q <= CNT_W'(DEPTH - 2));
      enq1    = ready && bus.pred_valid_1;
      enq2    = ready && bus.pred_valid_2;
      n_enq   = CNT_W'(enq1) + CNT_W'(enq2);
      // slot 2 packs directly behind slot 1, or into the tail when slot 1 is absent
      tail2   = tail_q + PTR_W'(enq1);
      do_res  = (state_q == ST_RUN) && bus.ex_valid && (count_q != '0);
      mispred = do_res && ((bus.ex_pc != pc_mem_q[head_q]) ||
                           (bus.ex_is_branch != br_mem_q[head_q]) ||
                           (bus.ex_taken != tk_mem_q[head_q]) ||
                           (bus.ex_taken && (bus.ex_target != tgt_mem_q[head_q])));
      next_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + ADDR_W'(4);
      wr1     = enq1 && !mispred;
      wr2     = enq2 && !mispred;

      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (state_q)
         ST_RUN: begin
            if (mispred) begin
               state_d = ST_FLUSH;
               head_d  = '0;
               tail_d  = '0;
               count_d = '0;
            end else begin
               head_d  = head_q + PTR_W'(do_res);
               tail_d  = tail_q + PTR_W'(enq1) + PTR_W'(enq2);
               count_d = count_q + n_enq - CNT_W'(do_res);
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase

      flush_d      = mispred;
      redirect_d   = mispred ? next_pc : '0;
      upd_valid_d  = do_res && (bus.ex_is_branch || br_mem_q[head_q]);
      upd_pc_d     = do_res ? bus.ex_pc        : upd_pc_q;
      upd_br_d     = do_res ? bus.ex_is_branch : upd_br_q;
      upd_tk_d     = do_res ? bus.ex_taken     : upd_tk_q;
      upd_target_d = do_res ? bus.ex_target    : upd_target_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         flush_q      <= 1'b0;
         redirect_q   <= '0;
         upd_valid_q  <= 1'b0;
         upd_pc_q     <= '0;
         upd_br_q     <= 1'b0;
         upd_tk_q     <= 1'b0;
         upd_target_q <= '0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         flush_q      <= flush_d;
         redirect_q   <= redirect_d;
         upd_valid_q  <= upd_valid_d;
         upd_pc_q     <= upd_pc_d;
         upd_br_q     <= upd_br_d;
         upd_tk_q     <= upd_tk_d;
         upd_target_q <= upd_target_d;
      end
   end

   // queue storage carries no reset; occupancy is tracked solely by the pointers
   always_ff @(posedge clk) begin
      if (!rst && wr1) begin
         pc_mem_q[tail_q]  <= bus.pred_pc_1;
         br_mem_q[tail_q]  <= bus.pred_is_branch_1;
         tk_mem_q[tail_q]  <= bus.pred_taken_1;
         tgt_mem_q[tail_q] <= bus.pred_target_1;
      end
      if (!rst && wr2) begin
         pc_mem_q[tail2]  <= bus.pred_pc_2;
         br_mem_q[tail2]  <= bus.pred_is_branch_2;
         tk_mem_q[tail2]  <= bus.pred_taken_2;
         tgt_mem_q[tail2] <= bus.pred_target_2;
      end
   end

`ifdef BRU_PERF_CNT_EN
   logic [31:0] perf_res_q, perf_res_d, perf_mis_q, perf_mis_d;

   always_comb begin
      perf_res_d = perf_res_q + 32'(upd_valid_d);
      perf_mis_d = perf_mis_q + 32'(flush_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_res_q <= '0;
         perf_mis_q <= '0;
      end else begin
         perf_res_q <= perf_res_d;
         perf_mis_q <= perf_mis_d;
      end
   end

   assign bus.perf_resolved_o = perf_res_q;
   assign bus.perf_mispred_o  = perf_mis_q;
`endif

   assign bus.pred_ready      = ready;
   assign bus.count_o         = count_q;
   assign bus.flush_o         = flush_q;
   assign bus.redirect_pc_o   = redirect_q;
   assign bus.upd_valid_o     = upd_valid_q;
   assign bus.upd_pc_o        = upd_pc_q;
   assign bus.upd_is_branch_o = upd_br_q;
   assign bus.upd_taken_o     = upd_tk_q;
   assign bus.upd_target_o    = upd_target_q;
endmodule

`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Back-end counterpart of the front-end branch predictor.
- Queues the per-slot predictions (pc, is_branch, taken, target) issued alongside fetched instructions.
- Checks each queued prediction in program order against the actual outcome from the execute stage.
- Emits a registered flush/redirect to the PC logic on mispredict.
- Emits a registered training write (update) back to the predictor tables for every resolved branch.

Parameters:
DEPTH, 8, prediction queue entries; power of 2, minimum 4.
ADDR_W, 32, address/instruction bus width.
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
pred_valid_1  in  1  slot-1 prediction present.
pred_pc_1  in  ADDR_W  slot-1 instruction pc.
pred_is_branch_1  in  1  slot-1 predicted as branch.
pred_taken_1  in  1  slot-1 predicted taken.
pred_target_1  in  ADDR_W  slot-1 predicted target.
pred_valid_2, pred_pc_2, pred_is_branch_2, pred_taken_2, pred_target_2  in  1/ADDR_W/1/1/ADDR_W  same fields for slot 2 (younger).
pred_ready  out  1  queue can accept two entries this cycle.
ex_valid  in  1  execute reports one resolved instruction.
ex_pc  in  ADDR_W  resolved instruction pc.
ex_is_branch  in  1  instruction is actually a branch/jump.
ex_taken  in  1  actual direction.
ex_target  in  ADDR_W  actual target.
flush_o  out  1  one-cycle mispredict pulse.
redirect_pc_o  out  ADDR_W  correct next pc; valid only while flush_o=1.
upd_valid_o  out  1  predictor training write strobe.
upd_pc_o  out  ADDR_W  pc to train.
upd_is_branch_o  out  1  actual branch flag.
upd_taken_o  out  1  actual direction.
upd_target_o  out  ADDR_W  actual target.
count_o  out  CNT_W  current queue occupancy.

Behaviour:
- Reset: head/tail pointers, count, and state cleared. All outputs 0 except pred_ready, which is 1. State goes to RUN. Reset overrides any enqueue or resolve in the same cycle.
- pred_ready: combinational, = (DEPTH - count >= 2) and (state == RUN).
- Enqueue, when pred_ready=1:
  - Each valid slot is written; slot 1 goes before slot 2.
  - pred_valid_2 alone writes one entry.
  - Invalid slots leave no hole.
  - Tail pointer advances by the number of valid slots, modulo DEPTH, wrapping freely.
- Resolve: when ex_valid=1 and count>0, the head entry is popped and compared.
  - Mispredict if any of:
    - ex_pc != head.pc;
    - ex_is_branch != head.is_branch;
    - ex_taken != head.taken;
    - ex_taken=1 and ex_target != head.target.
  - Correct next pc = ex_taken ? ex_target : ex_pc + 4, with 32-bit modular add.
- ex_valid with count=0: ignored. No pop, no update, no flush.
- Simultaneous enqueue and pop in RUN: both occur. count_next = count + n_enq - 1. pred_ready uses the pre-edge count.
- State machine:
  - RUN, on a resolve that mispredicts: next state FLUSH. At the same edge, the queue is emptied (pointers and count to 0) and any same-cycle enqueue is dropped.
  - FLUSH: lasts exactly one cycle. flush_o=1 and redirect_pc_o = correct next pc. pred_valid_* are ignored (wrong-path) and ex_valid is ignored. Next state is RUN.
  - RUN, on a correct resolve: stays in RUN.
- Latency:
  - flush_o, redirect_pc_o, and upd_* are registered, one cycle after the ex_valid cycle.
  - upd_valid_o pulses for every resolve where ex_is_branch=1 or head.is_branch=1, so a false-positive prediction is also trained.
  - upd_* fields carry the ex_* values.
  - upd_valid_o coincides with flush_o when the resolve mispredicted.
- Back-to-back resolves in RUN: one per cycle, with no bubble.

Optional Feature:
Macro BRU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_resolved_o[31:0] and perf_mispred_o[31:0].
  - perf_resolved_o increments on every resolve whose upd_valid_o is set. perf_mispred_o increments on every mispredict.
  - Both are updated at the same edge as upd_valid_o/flush_o, wrap at 2^32, and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then enqueue slot1 {pc=0x1c000000, branch, taken, tgt=0x1c000040} and slot2 {pc=0x1c000004, non-branch}. count_o=2. Then ex resolves 0x1c000000 taken to 0x1c000040 -> next cycle upd_valid_o=1, upd_pc_o=0x1c000000, flush_o=0, count_o=1.
2. Head predicted not-taken at pc=0x1c000100; ex reports taken to 0x1c000200 -> next cycle flush_o=1, redirect_pc_o=0x1c000200, count_o=0. pred_ready=0 during the FLUSH cycle and 1 the cycle after.
3. Head predicted taken at pc=0x1c000300; ex reports not-taken -> redirect_pc_o=0x1c000304 with flush_o=1. A pred_valid_1 asserted in the mispredict cycle is not enqueued (count_o=0).
4. Fill to DEPTH-1=7 entries -> pred_ready=0. Resolve one correct entry (count 6) -> pred_ready=1. Continue enqueueing and resolving across 3×DEPTH entries -> pointers wrap, and resolves return entries in exact enqueue order.
5. ex_valid with an empty queue -> no upd_valid_o, no flush_o, count_o stays 0. Predicted-branch entry resolved as non-branch -> flush_o=1, upd_valid_o=1, upd_is_branch_o=0.
6. With BRU_PERF_CNT_EN: scenarios 1+2 -> perf_resolved_o=2, perf_mispred_o=1. Assert rst mid-sequence -> both counters 0, count_o=0, flush_o=0.
